// File: rtl/serial_add_ctrl.sv
// Bit-serial N-bit adder: one shared half_adder, used twice per bit (PH1 a^b, PH2 with carry-in),
// yields a registered sum and carry_out plus a one-cycle done pulse.

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             done,
  output logic             busy
);
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, PH1, PH2, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_q, b_q, res, next_res;
  logic [IW-1:0]    idx;
  logic             cin, s1, c1;
  logic             ha_a, ha_b, ha_sum, ha_carry;

  // PH1 adds the operand bits; PH2 folds in the carry from the previous bit.
  always_comb begin
    ha_a = s1;
    ha_b = cin;
    if (state == PH1) begin
      ha_a = a_q[idx];
      ha_b = b_q[idx];
    end
  end

  half_adder u_ha (
    .a    (ha_a),
    .b    (ha_b),
    .sum  (ha_sum),
    .carry(ha_carry)
  );

  always_comb begin
    next_res      = res;
    next_res[idx] = ha_sum;
  end

  assign start_ready = (state == IDLE) && !rst;
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      res       <= '0;
      idx       <= '0;
      cin       <= 1'b0;
      s1        <= 1'b0;
      c1        <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_valid) begin
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            cin   <= 1'b0;
            res   <= '0;
            state <= PH1;
          end
        end
        PH1: begin
          s1    <= ha_sum;
          c1    <= ha_carry;
          state <= PH2;
        end
        PH2: begin
          // The final bit publishes the result directly so partial sums never reach the outputs.
          res <= next_res;
          cin <= c1 | ha_carry;
          if (idx == LAST) begin
            sum       <= next_res;
            carry_out <= c1 | ha_carry;
            done      <= 1'b1;
            state     <= DONE;
          end else begin
            idx   <= idx + IW'(1);
            state <= PH1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/serial_add_ctrl.md
# serial_add_ctrl

Bit-serial multi-bit adder controller that sequences a single shared `half_adder` instance to compute an N-bit sum plus carry-out. It accepts operands over a valid/ready handshake and time-multiplexes the one half-adder cell through two phases per bit, forming a full-adder step. It returns the registered result with a one-cycle `done` pulse. It sits between a requesting datapath and the existing `half_adder` cell, trading latency for area.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range is 1 or greater.
- `clk`  input  1  sole clock, rising-edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start_valid`  input  1  requester has operands on `a`/`b`.
- `start_ready`  output  1  block can accept; high only in IDLE with `rst` low.
- `a`  input  WIDTH  operand A, sampled on accept.
- `b`  input  WIDTH  operand B, sampled on accept.
- `sum`  output  WIDTH  registered result of `a+b` (low WIDTH bits).
- `carry_out`  output  1  registered carry out of bit WIDTH-1.
- `done`  output  1  one-cycle pulse; result valid.
- `busy`  output  1  high in PH1, PH2 and DONE.

## Operation
- Exactly one `half_adder` instance; all arithmetic passes through it. No other adder logic.
- Accept occurs when `start_valid && start_ready` at a rising edge. On accept:
  - Capture `a` and `b` into internal operand registers.
  - Clear the bit index, the carry register `cin`, and the partial result.
  - Later changes on `a`/`b` have no effect.
- FSM states: IDLE, PH1, PH2, DONE.
  - IDLE to PH1 on accept; otherwise stay in IDLE.
  - PH1: drive the half adder with (`a_q[i]`, `b_q[i]`). Latch `s1 = sum` and `c1 = carry`. Go to PH2.
  - PH2: drive the half adder with (`s1`, `cin`). Write `res[i] = sum` and set `cin = c1 | carry`.
    - If `i == WIDTH-1`, go to DONE.
    - Else increment `i` and go to PH1.
  - DONE: `done = 1`. Load `sum <= res` and `carry_out <= cin` on entry to DONE. Go to IDLE unconditionally.
- Bit index counter width is max(1, $clog2(WIDTH)). The index never wraps inside an operation.
- `sum`/`carry_out` change only on entry to DONE. They hold the last result until the next DONE entry or reset. Intermediate bits are never visible.
- `start_ready = (state == IDLE) && !rst` (combinational). `busy = (state != IDLE)`.
- Reset mid-operation:
  - Immediately forces IDLE and clears all registers, including `sum` and `carry_out`.
  - `done` goes to 0. The in-flight operation is discarded with no `done` pulse.

## Timing
- Reset values: `start_ready` = 1 once `rst` deasserts (0 while asserted); `sum` = 0; `carry_out` = 0; `done` = 0; `busy` = 0.
- Accept at edge ending cycle T. Bit i is in PH1 in cycle T+1+2i and in PH2 in cycle T+2+2i.
- DONE (`done` = 1, new `sum`/`carry_out` visible) in cycle T+2·WIDTH+1. For WIDTH=8 this is T+17.
- `start_ready` is 0 from T+1 through T+2·WIDTH+1 and returns to 1 in T+2·WIDTH+2.
- Back-to-back throughput is one operation per 2·WIDTH+2 cycles.
- `done` is never high for two consecutive cycles.
- WIDTH=1: PH1 at T+1, PH2 at T+2, DONE at T+3.
- `start_valid` is ignored outside IDLE. No request is queued or buffered.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs at reset values in the same cycle. After release, `start_ready` = 1.
- WIDTH=8, `a`=8'hFF, `b`=8'h01, accepted at T → `done` at T+17 with `sum`=8'h00, `carry_out`=1. Also `a`=8'h5A, `b`=8'hA5 → `sum`=8'hFF, `carry_out`=0.
- Hold `start_valid` high with a second operand pair (8'h80+8'h80) → second accept at T+18. Its `done` is at T+35 with `sum`=8'h00, `carry_out`=1. The first result holds stable from T+17 to T+34.
- Change `a`/`b` every cycle after accepting 8'h0F+8'h01 → result 8'h10, `carry_out`=0. This shows the inputs were not resampled.
- Assert `rst` during PH2 of bit 3 → no `done` pulse. `sum`=0, `carry_out`=0. A new 8'h33+8'h44 after release gives 8'h77 at its T+17.
- Random regression, 1000 operations for WIDTH in {1, 8, 16} → {`carry_out`,`sum`} equals `a+b` on every `done`. Also check `done` count equals accept count.
